// File: rtl/div_pkg.sv
// Shared types and helpers for the divider sequencer: op encoding, FSM states,
// and the magnitude/negation helpers used on both the operand and result sides.
package div_pkg;
   localparam int          XLEN     = 32;
   localparam logic [31:0] INT_MIN  = 32'h8000_0000;
   localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_t;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT,
      RESP
   } div_state_t;

   // funct3[0] clear means a signed op
   function automatic logic op_signed(div_op_t op);
      return ~op[0];
   endfunction

   function automatic logic [31:0] neg_if(logic n, logic [31:0] v);
      return n ? (~v + 32'd1) : v;
   endfunction
endpackage

// File: rtl/div_unit_if.sv
// Request/response handshake plus the divider-side strobe bus for div_unit.
interface div_unit_if;
   import div_pkg::*;

   logic        in_valid;
   logic        in_ready;
   div_op_t     op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        div_start;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic [31:0] div_q;
   logic [31:0] div_r;
   logic        div_done;

   modport slave (
      input  in_valid, op, a, b, flush, out_ready, div_q, div_r, div_done,
      output in_ready, out_valid, result, div_start, div_a, div_b
   );

   modport master (
      output in_valid, op, a, b, flush, out_ready, div_q, div_r, div_done,
      input  in_ready, out_valid, result, div_start, div_a, div_b
   );
endinterface

// File: rtl/div_special.sv
// Combinational detection of the operand combinations the iterative divider
// cannot handle, with the architecturally defined result for each.
module div_special
   import div_pkg::*;
(
   input  div_op_t     op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        hit,
   output logic [31:0] value
);
   logic [31:0] q;
   logic [31:0] r;

   always_comb begin
      hit = 1'b0;
      q   = '0;
      r   = a;
      if (b == '0) begin
         hit = 1'b1;
         q   = ALL_ONES;
         r   = a;
      end else if (op_signed(op) && a == INT_MIN && b == ALL_ONES) begin
         hit = 1'b1;
         q   = INT_MIN;
         r   = '0;
      end else if (!op_signed(op) && b[31]) begin
         // quotient can only be 0 or 1 when the divisor has its top bit set
         hit = 1'b1;
         q   = (a >= b) ? 32'd1 : 32'd0;
         r   = q[0] ? (a - b) : a;
      end
      value = op[1] ? r : q;
   end
endmodule

// File: rtl/div_unit.sv
// Sequencer in front of the shared iterative divider: filters special cases,
// feeds magnitudes to the divider, sign-fixes its result and holds it for the consumer.
module div_unit
   import div_pkg::*;
#(
   parameter int XLEN = 32
) (
   input logic       clk,
   input logic       N_reset,
   div_unit_if.slave bus
);
   div_state_t      state;
   div_op_t         op_q;
   logic            a_neg, b_neg;
   logic            out_valid_q, div_start_q;
   logic [XLEN-1:0] result_q, div_a_q, div_b_q;

   logic            sp_hit;
   logic [XLEN-1:0] sp_val;
   logic            in_signed;
   logic [XLEN-1:0] mag_a, mag_b;
   logic            fix_neg;
   logic [XLEN-1:0] fix_val;

   div_special u_special (
      .op    (bus.op),
      .a     (bus.a),
      .b     (bus.b),
      .hit   (sp_hit),
      .value (sp_val)
   );

   assign in_signed = op_signed(bus.op);
   assign mag_a     = neg_if(in_signed & bus.a[31], bus.a);
   assign mag_b     = neg_if(in_signed & bus.b[31], bus.b);

   // remainder takes the dividend's sign, quotient the xor of both
   assign fix_neg = op_signed(op_q) & (op_q[1] ? a_neg : (a_neg ^ b_neg));
   assign fix_val = neg_if(fix_neg, op_q[1] ? bus.div_r : bus.div_q);

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.div_start = div_start_q;
   assign bus.div_a     = div_a_q;
   assign bus.div_b     = div_b_q;

   always_ff @(posedge clk or negedge N_reset) begin
      if (!N_reset) begin
         state       <= IDLE;
         op_q        <= DIV;
         a_neg       <= 1'b0;
         b_neg       <= 1'b0;
         out_valid_q <= 1'b0;
         div_start_q <= 1'b0;
         result_q    <= '0;
         div_a_q     <= '0;
         div_b_q     <= '0;
      end else begin
         div_start_q <= 1'b0;
         if (bus.flush) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
         end else begin
            case (state)
               IDLE: if (bus.in_valid) begin
                  op_q    <= bus.op;
                  a_neg   <= bus.a[31];
                  b_neg   <= bus.b[31];
                  div_a_q <= mag_a;
                  div_b_q <= mag_b;
                  if (sp_hit) begin
                     result_q    <= sp_val;
                     out_valid_q <= 1'b1;
                     state       <= RESP;
                  end else begin
                     div_start_q <= 1'b1;
                     state       <= LAUNCH;
                  end
               end
               // done may still be high from a previous run here; not sampled
               LAUNCH: state <= WAIT;
               WAIT: if (bus.div_done) begin
                  result_q    <= fix_val;
                  out_valid_q <= 1'b1;
                  state       <= RESP;
               end
               RESP: if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit with a behavioural 33-cycle divider whose done
// flag stays high after finishing, so early sampling returns stale data.
module tb_div_unit;
   import div_pkg::*;

   logic clk = 1'b0;
   logic N_reset = 1'b0;
   always #5 clk = ~clk;

   div_unit_if bus ();

   div_unit #(.XLEN(32)) dut (
      .clk     (clk),
      .N_reset (N_reset),
      .bus     (bus.slave)
   );

   int checks = 0;
   int failures = 0;
   logic [31:0] sb[$];

   // divider model: done in the 33rd cycle after the start cycle, then sticky
   logic [31:0] m_q = '0, m_r = '0;
   int          m_cnt = 0;
   logic        m_stale = 1'b0;
   always @(posedge clk) begin
      if (bus.div_start) begin
         m_cnt   <= 33;
         m_stale <= 1'b0;
         m_q     <= (bus.div_b != 0) ? bus.div_a / bus.div_b : 32'hFFFF_FFFF;
         m_r     <= (bus.div_b != 0) ? bus.div_a % bus.div_b : bus.div_a;
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) m_stale <= 1'b1;
      end
   end
   assign bus.div_done = (m_cnt == 1) | m_stale;
   assign bus.div_q    = m_q;
   assign bus.div_r    = m_r;

   function automatic logic [31:0] ref_res(div_op_t o, logic [31:0] x, logic [31:0] y);
      logic signed [31:0] sx, sy, t;
      logic ovf;
      sx = x;
      sy = y;
      ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      if (o == DIV) begin
         if (y == 0) return 32'hFFFF_FFFF;
         if (ovf) return 32'h8000_0000;
         t = sx / sy;
         return t;
      end else if (o == REM) begin
         if (y == 0) return x;
         if (ovf) return 32'h0;
         t = sx % sy;
         return t;
      end else if (o == DIVU) begin
         return (y == 0) ? 32'hFFFF_FFFF : x / y;
      end
      return (y == 0) ? x : x % y;
   endfunction

   function automatic bit is_special(div_op_t o, logic [31:0] x, logic [31:0] y);
      bit sgn;
      sgn = (o == DIV) || (o == REM);
      return (y == 0) || (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) || (!sgn && y[31]);
   endfunction

   task automatic send(input div_op_t o, input logic [31:0] x, input logic [31:0] y, input bit push);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         checks++; failures++;
         $display("FAIL accept_timeout in_ready=%0b required=1", bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.op = o;
      bus.a = x;
      bus.b = y;
      if (push) sb.push_back(ref_res(o, x, y));
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   // cycle index c counts from the acceptance cycle (cycle 0)
   task automatic wait_resp(output int lat, output int st, output logic [31:0] da, output logic [31:0] db);
      lat = -1; st = -1; da = '0; db = '0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (bus.div_start && st < 0) begin
            st = c; da = bus.div_a; db = bus.div_b;
         end
         if (bus.out_valid) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic run(input string nm, input div_op_t o, input logic [31:0] x, input logic [31:0] y,
                      output logic [31:0] da, output logic [31:0] db);
      int lat, st, elat, est;
      logic [31:0] exp;
      elat = is_special(o, x, y) ? 1 : 35;
      est  = is_special(o, x, y) ? -1 : 1;
      send(o, x, y, 1'b1);
      wait_resp(lat, st, da, db);
      exp = sb.pop_front();
      checks++;
      if (lat < 0) begin
         failures++;
         $display("FAIL %s_timeout out_valid never rose", nm);
         return;
      end
      if (bus.result !== exp) begin
         failures++;
         $display("FAIL %s_result got=%h expected=%h", nm, bus.result, exp);
      end
      checks++;
      if (lat != elat) begin
         failures++;
         $display("FAIL %s_latency got=%0d expected=%0d", nm, lat, elat);
      end
      checks++;
      if (st != est) begin
         failures++;
         $display("FAIL %s_start_cycle got=%0d expected=%0d", nm, st, est);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1 N_reset = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.div_start !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_state ov=%b res=%h st=%b rdy=%b expected 0/0/0/1",
                  bus.out_valid, bus.result, bus.div_start, bus.in_ready);
      end
   endtask

   task automatic test_unsigned();
      logic [31:0] da, db;
      run("divu_100_7", DIVU, 32'd100, 32'd7, da, db);
      checks++;
      if (da !== 32'd100 || db !== 32'd7) begin
         failures++;
         $display("FAIL divu_operands got=%h/%h expected=00000064/00000007", da, db);
      end
      run("remu_100_7", REMU, 32'd100, 32'd7, da, db);
   endtask

   task automatic test_signed();
      logic [31:0] da, db;
      run("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, da, db);
      checks++;
      if (da !== 32'd7 || db !== 32'd2) begin
         failures++;
         $display("FAIL div_magnitudes got=%h/%h expected=00000007/00000002", da, db);
      end
      run("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, da, db);
      run("div_intmin_2", DIV, 32'h8000_0000, 32'd2, da, db);
      checks++;
      if (da !== 32'h8000_0000) begin
         failures++;
         $display("FAIL intmin_magnitude got=%h expected=80000000", da);
      end
   endtask

   task automatic test_special();
      logic [31:0] da, db;
      run("div_by_zero", DIV, 32'd5, 32'd0, da, db);
      run("rem_by_zero", REM, 32'd5, 32'd0, da, db);
      run("div_overflow", DIV, 32'h8000_0000, 32'hFFFF_FFFF, da, db);
      run("rem_overflow", REM, 32'h8000_0000, 32'hFFFF_FFFF, da, db);
      run("divu_big_b", DIVU, 32'hF000_0000, 32'h9000_0000, da, db);
      run("remu_big_b", REMU, 32'hF000_0000, 32'h9000_0000, da, db);
      run("divu_big_b_lt", DIVU, 32'h7000_0000, 32'h9000_0000, da, db);
   endtask

   task automatic test_backpressure();
      int lat, st;
      logic [31:0] da, db, exp;
      bus.out_ready = 1'b0;
      send(DIVU, 32'd9, 32'd3, 1'b1);
      wait_resp(lat, st, da, db);
      exp = sb.pop_front();
      checks++;
      if (lat < 0) begin
         failures++;
         $display("FAIL bp_timeout out_valid never rose");
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.result !== exp || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold_%0d res=%h rdy=%b ov=%b expected %h/0/1",
                     i, bus.result, bus.in_ready, bus.out_valid, exp);
         end
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release ov=%b rdy=%b expected 0/1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic quiet_window(input string nm);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL %s_quiet out_valid=1 expected=0", nm);
      end
   endtask

   task automatic test_flush();
      int lat, st;
      logic [31:0] da, db;
      send(DIVU, 32'd1000, 32'd3, 1'b0);
      repeat (11) @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.flush = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_idle rdy=%b ov=%b expected 1/0", bus.in_ready, bus.out_valid);
      end
      quiet_window("flush");
      run("flush_next_8_2", DIVU, 32'd8, 32'd2, da, db);
      // flush wins over a pending response and over a simultaneous out_ready
      send(DIV, 32'd5, 32'd0, 1'b0);
      wait_resp(lat, st, da, db);
      bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.flush = 1'b0;
      @(negedge clk);
      checks++;
      if (lat != 1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL flush_resp lat=%0d ov=%b rdy=%b expected 1/0/1", lat, bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_reset_abort();
      logic [31:0] da, db;
      send(DIVU, 32'd1000, 32'd3, 1'b0);
      repeat (11) @(negedge clk);
      N_reset = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.div_start !== 1'b0) begin
         failures++;
         $display("FAIL rst_abort ov=%b rdy=%b st=%b expected 0/1/0", bus.out_valid, bus.in_ready, bus.div_start);
      end
      @(posedge clk);
      #1 N_reset = 1'b1;
      quiet_window("rst");
      run("rst_next_8_2", DIVU, 32'd8, 32'd2, da, db);
   endtask

   task automatic test_random();
      logic [31:0] da, db, x, y;
      div_op_t o;
      for (int i = 0; i < 12; i++) begin
         o = div_op_t'(i % 4);
         x = $urandom;
         case (i / 4)
            0:       y = $urandom_range(1, 1000);
            1:       y = $urandom;
            default: y = 32'd0 - $urandom_range(1, 50);
         endcase
         run("random", o, x, y, da, db);
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.op = DIV;
      bus.a = '0;
      bus.b = '0;
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      test_reset();
      test_unsigned();
      test_signed();
      test_special();
      test_backpressure();
      test_flush();
      test_reset_abort();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
